vc_test_rand_delay_sink: RTL and testbench

//  Test-harness sink for the val/rdy message interface. Applies a pseudo-random

---
 rtl/vc_test_pkg.sv | 5 +
 rtl/vc_test_lfsr32.sv | 13 +
 rtl/vc_test_rand_delay_sink.sv | 84 ++++++++
 tb/tb_vc_test_rand_delay_sink.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vc_test_pkg.sv
// vc_test_pkg: shared FSM encodings and LFSR constants for the val/rdy test harness blocks.
package vc_test_pkg;
  typedef enum logic {IDLE, DELAY} state_t;
  localparam logic [31:0] c_lfsr_poly = 32'h80200003;
endpackage

// File: rtl/vc_test_lfsr32.sv
// vc_test_lfsr32: free-running 32-bit Galois LFSR, reloaded with p_seed on reset.
module vc_test_lfsr32
  import vc_test_pkg::*;
#(
  parameter logic [31:0] p_seed = 32'h1
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] lfsr
);
  always_ff @(posedge clk)
    lfsr <= reset ? p_seed : (lfsr >> 1) ^ (lfsr[0] ? c_lfsr_poly : 32'h0);
endmodule

// File: rtl/vc_test_rand_delay_sink.sv
// vc_test_rand_delay_sink: val/rdy sink with random pre-transfer stalls, checking messages against a table.
module vc_test_rand_delay_sink
  import vc_test_pkg::*;
#(
  parameter int          p_msg_sz    = 8,
  parameter int          p_max_delay = 0,
  parameter int          p_num_msgs  = 16,
  parameter logic [31:0] p_seed      = 32'h1,
  localparam int         c_addr_sz   = (p_num_msgs > 1) ? $clog2(p_num_msgs) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_val,
  output logic                in_rdy,
  input  logic [p_msg_sz-1:0] in_msg,
  input  logic                exp_wen,
  input  logic [c_addr_sz-1:0] exp_waddr,
  input  logic [p_msg_sz-1:0] exp_wdata,
  input  logic [c_addr_sz:0]  exp_num,
  output logic                done,
  output logic                error,
  output logic [c_addr_sz-1:0] error_idx,
  output logic [p_msg_sz-1:0] error_got,
  output logic [p_msg_sz-1:0] error_exp,
  output logic [31:0]         rand_num
);
  logic [31:0]         lfsr;
  logic [31:0]         cnt, cnt_n;
  state_t              state, state_n;
  logic [c_addr_sz:0]  recv_cnt, exp_clamp;
  logic [p_msg_sz-1:0] tbl [0:p_num_msgs-1];
  logic [p_msg_sz-1:0] exp_msg;
  logic                xfer;

  vc_test_lfsr32 #(.p_seed(p_seed)) u_lfsr (.clk(clk), .reset(reset), .lfsr(lfsr));

  assign rand_num  = (p_max_delay == 0) ? 32'd0 : lfsr % 32'(p_max_delay + 1);
  assign exp_clamp = (exp_num > (c_addr_sz+1)'(p_num_msgs)) ? (c_addr_sz+1)'(p_num_msgs) : exp_num;
  assign done      = recv_cnt == exp_clamp;
  assign in_rdy    = !done && ((state == IDLE) ? rand_num == 32'd0 : cnt == 32'd0);
  assign xfer      = in_val && in_rdy;
  assign exp_msg   = tbl[recv_cnt[c_addr_sz-1:0]];

  // A stall of N cycles is one IDLE cycle plus N-1 counted DELAY cycles.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    if (state == IDLE && in_val && !in_rdy && rand_num != 32'd0) begin
      state_n = DELAY;
      cnt_n   = rand_num - 32'd1;
    end else if (state == DELAY) begin
      cnt_n   = (cnt != 32'd0) ? cnt - 32'd1 : cnt;
      state_n = xfer ? IDLE : DELAY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      recv_cnt  <= '0;
      error     <= 1'b0;
      error_idx <= '0;
      error_got <= '0;
      error_exp <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (xfer) begin
        recv_cnt <= recv_cnt + (c_addr_sz+1)'(1);
        if (in_msg != exp_msg && !error) begin
          error     <= 1'b1;
          error_idx <= recv_cnt[c_addr_sz-1:0];
          error_got <= in_msg;
          error_exp <= exp_msg;
        end
      end
    end
  end

  // The table survives reset so a harness can reload it once and rerun.
  always_ff @(posedge clk)
    if (exp_wen) tbl[exp_waddr] <= exp_wdata;
endmodule

// File: tb/tb_vc_test_rand_delay_sink.sv
// tb_vc_test_rand_delay_sink: checks a zero-delay and a max-delay-3 sink against a behavioural model.
module tb_vc_test_rand_delay_sink;
  logic        clk = 1'b0;
  logic        reset, in_val, exp_wen;
  logic [7:0]  in_msg, exp_wdata;
  logic [3:0]  exp_waddr;
  logic [4:0]  exp_num;
  logic        rdy0, done0, err0, rdy3, done3, err3;
  logic [3:0]  eidx0, eidx3;
  logic [7:0]  egot0, eexp0, egot3, eexp3;
  logic [31:0] rnum0, rnum3;
  logic [31:0] m;
  logic [7:0]  exp_tbl [16];
  int          checks = 0, failures = 0;

  always #5 clk = ~clk;

  vc_test_rand_delay_sink #(.p_msg_sz(8), .p_max_delay(0), .p_num_msgs(16), .p_seed(32'h1)) dut0 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy0), .in_msg(in_msg),
    .exp_wen(exp_wen), .exp_waddr(exp_waddr), .exp_wdata(exp_wdata), .exp_num(exp_num),
    .done(done0), .error(err0), .error_idx(eidx0), .error_got(egot0), .error_exp(eexp0),
    .rand_num(rnum0));

  vc_test_rand_delay_sink #(.p_msg_sz(8), .p_max_delay(3), .p_num_msgs(16), .p_seed(32'h1)) dut3 (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(rdy3), .in_msg(in_msg),
    .exp_wen(exp_wen), .exp_waddr(exp_waddr), .exp_wdata(exp_wdata), .exp_num(exp_num),
    .done(done3), .error(err3), .error_idx(eidx3), .error_got(egot3), .error_exp(eexp3),
    .rand_num(rnum3));

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
  endfunction

  always @(posedge clk) m <= reset ? 32'h1 : lfsr_step(m);

  task automatic do_reset;
    reset = 1'b1;
    in_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
  endtask

  task automatic write_tbl(input int i, input logic [7:0] d);
    exp_wen = 1'b1;
    exp_waddr = 4'(i);
    exp_wdata = d;
    @(negedge clk);
    exp_wen = 1'b0;
    exp_tbl[i] = d;
  endtask

  task automatic send0(input logic [7:0] d);
    in_val = 1'b1;
    in_msg = d;
    #1;
    checks++;
    if (rdy0 !== 1'b1) begin failures++; $display("FAIL send0_rdy got=%b exp=1 msg=%h", rdy0, d); end
    @(negedge clk);
    in_val = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    checks++;
    if (rdy0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL reset_rdy_done got=%b%b exp=10", rdy0, done0); end
    checks++;
    if ({err0, eidx0, egot0, eexp0} !== 21'h0) begin failures++; $display("FAIL reset_err got=%h exp=0", {err0, eidx0, egot0, eexp0}); end
    checks++;
    if (rnum0 !== 32'd0 || rnum3 !== 32'd1) begin failures++; $display("FAIL reset_rand got=%0d,%0d exp=0,1", rnum0, rnum3); end
    checks++;
    if (rdy3 !== 1'b0 || done3 !== 1'b0) begin failures++; $display("FAIL reset_rdy3 got=%b%b exp=00", rdy3, done3); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 4; k++) send0(exp_tbl[k]);
    checks++;
    if (done0 !== 1'b1 || rdy0 !== 1'b0 || err0 !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b%b%b exp=100", done0, rdy0, err0); end
  endtask

  task automatic test_mismatch;
    logic [7:0] msgs [4];
    msgs = '{8'h11, 8'h23, 8'h33, 8'h45};
    do_reset;
    for (int k = 0; k < 4; k++) begin
      send0(msgs[k]);
      if (k == 0) begin
        checks++;
        if (err0 !== 1'b0) begin failures++; $display("FAIL mism_early got=%b exp=0", err0); end
      end
    end
    checks++;
    if (err0 !== 1'b1 || eidx0 !== 4'd1) begin failures++; $display("FAIL mism_idx got=%b/%0d exp=1/1", err0, eidx0); end
    checks++;
    if (egot0 !== 8'h23 || eexp0 !== 8'h22) begin failures++; $display("FAIL mism_data got=%h/%h exp=23/22", egot0, eexp0); end
    checks++;
    if (done0 !== 1'b1) begin failures++; $display("FAIL mism_done got=%b exp=1", done0); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    send0(exp_tbl[0]);
    send0(8'h99);
    @(negedge clk);
    #1;
    checks++;
    if (err0 !== 1'b1) begin failures++; $display("FAIL mid_pre_err got=%b exp=1", err0); end
    do_reset;
    checks++;
    if ({err0, eidx0, egot0, eexp0, done0} !== 22'h0 || rdy0 !== 1'b1) begin failures++; $display("FAIL mid_reset got=%h rdy=%b exp=0 rdy=1", {err0, eidx0, egot0, eexp0, done0}, rdy0); end
    for (int k = 0; k < 4; k++) send0(exp_tbl[k]);
    checks++;
    if (done0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL mid_resend got=%b%b exp=10", done0, err0); end
  endtask

  task automatic test_zero_num;
    exp_num = 5'd0;
    do_reset;
    in_val = 1'b1;
    in_msg = exp_tbl[0];
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (done0 !== 1'b1 || rdy0 !== 1'b0 || done3 !== 1'b1 || rdy3 !== 1'b0) begin failures++; $display("FAIL zero_num cyc=%0d got=%b%b%b%b exp=1010", i, done0, rdy0, done3, rdy3); end
      @(negedge clk);
      #1;
    end
    in_val = 1'b0;
    exp_num = 5'd1;
    #1;
    checks++;
    if (done0 !== 1'b0 || done3 !== 1'b0) begin failures++; $display("FAIL zero_no_xfer got=%b%b exp=00", done0, done3); end
    exp_num = 5'd4;
  endtask

  task automatic test_collision;
    exp_num = 5'd1;
    do_reset;
    in_val = 1'b1;
    in_msg = 8'h11;
    exp_wen = 1'b1;
    exp_waddr = 4'd0;
    exp_wdata = 8'h77;
    @(negedge clk);
    exp_wen = 1'b0;
    in_val = 1'b0;
    exp_tbl[0] = 8'h77;
    #1;
    checks++;
    if (done0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL collide_old got=%b%b exp=10", done0, err0); end
    do_reset;
    send0(8'h77);
    checks++;
    if (done0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL collide_new got=%b%b exp=10", done0, err0); end
    write_tbl(0, 8'h11);
    exp_num = 5'd4;
  endtask

  task automatic test_random_delay;
    int stall;
    logic [31:0] r;
    for (int i = 0; i < 16; i++) write_tbl(i, 8'($urandom));
    exp_num = 5'd16;
    do_reset;
    for (int k = 0; k < 16; k++) begin
      in_val = 1'b1;
      in_msg = exp_tbl[k];
      #1;
      r = m % 32'd4;
      stall = 0;
      checks++;
      if (rnum3 !== r) begin failures++; $display("FAIL rand_draw msg=%0d got=%0d exp=%0d", k, rnum3, r); end
      while (rdy3 !== 1'b1 && stall < 10) begin
        @(negedge clk);
        #1;
        stall++;
        checks++;
        if (rnum3 !== m % 32'd4) begin failures++; $display("FAIL rand_track got=%0d exp=%0d", rnum3, m % 32'd4); end
      end
      checks++;
      if (32'(stall) !== r) begin failures++; $display("FAIL stall_len msg=%0d got=%0d exp=%0d", k, stall, r); end
      @(negedge clk);
    end
    in_val = 1'b0;
    #1;
    checks++;
    if (done3 !== 1'b1 || err3 !== 1'b0 || rdy3 !== 1'b0) begin failures++; $display("FAIL rand_end got=%b%b%b exp=100", done3, err3, rdy3); end
    exp_num = 5'd20;
    #1;
    checks++;
    if (done3 !== 1'b1) begin failures++; $display("FAIL clamp got=%b exp=1", done3); end
    exp_num = 5'd15;
    #1;
    checks++;
    if (done3 !== 1'b0) begin failures++; $display("FAIL under_num got=%b exp=0", done3); end
  endtask

  task automatic test_stall_drop;
    logic [31:0] r;
    int waited;
    exp_num = 5'd1;
    do_reset;
    in_msg = exp_tbl[0];
    waited = 0;
    while (m % 32'd4 != 32'd3 && waited < 200) begin
      @(negedge clk);
      #1;
      waited++;
    end
    checks++;
    if (waited >= 200) begin failures++; $display("FAIL drop_seek got=timeout exp=draw3"); end
    r = m % 32'd4;
    in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      #1;
      checks++;
      if (rdy3 !== (32'(i) >= r)) begin failures++; $display("FAIL drop_rdy cyc=%0d got=%b exp=%b", i, rdy3, 32'(i) >= r); end
      if (i < 5) @(negedge clk);
    end
    checks++;
    if (done3 !== 1'b0) begin failures++; $display("FAIL drop_no_xfer got=%b exp=0", done3); end
    in_val = 1'b1;
    @(negedge clk);
    in_val = 1'b0;
    #1;
    checks++;
    if (done3 !== 1'b1 || err3 !== 1'b0) begin failures++; $display("FAIL drop_xfer got=%b%b exp=10", done3, err3); end
  endtask

  initial begin
    reset = 1'b1;
    in_val = 1'b0;
    in_msg = 8'h0;
    exp_wen = 1'b0;
    exp_waddr = 4'd0;
    exp_wdata = 8'h0;
    exp_num = 5'd4;
    @(negedge clk);
    write_tbl(0, 8'h11);
    write_tbl(1, 8'h22);
    write_tbl(2, 8'h33);
    write_tbl(3, 8'h44);
    do_reset;
    test_reset;
    test_back_to_back;
    test_mismatch;
    test_reset_mid;
    test_zero_num;
    test_collision;
    test_random_delay;
    test_stall_drop;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
